// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM encoding, default width and the
// quotient value reported for a zero divisor.
package div_defs;

  localparam int unsigned DIV_WIDTH = 32;

  // Architecturally undefined; this is the value we choose to return.
  localparam logic [DIV_WIDTH-1:0] DIV_BYZERO_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BUSY   = 2'b01,
    DIV_BYZERO = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it is non-negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitudes are divided by a restoring iteration, signs are
// restored on entry to DONE, and the combinational stall holds F/D/E while work is pending.
module div_unit
  import div_defs::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  input  logic               pipe_stall_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_div_o
);

  div_state_e state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sgn_q, sgn_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0] op1_abs, op2_abs;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    op1_abs = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    op2_abs = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    quo_fix = (sgn_q && (sa_q != sb_q)) ? -step_quo : step_quo;
    rem_fix = (sgn_q && sa_q) ? -step_rem : step_rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    if (annul_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            if (opdata2_i == '0) begin
              state_d = DIV_BYZERO;
              quo_d   = opdata1_i;  // raw dividend becomes HI
            end else begin
              state_d = DIV_BUSY;
              rem_d   = '0;
              quo_d   = op1_abs;
              dvs_d   = op2_abs;
              sgn_d   = signed_i;
              sa_d    = opdata1_i[WIDTH-1];
              sb_d    = opdata2_i[WIDTH-1];
              cnt_d   = '0;
            end
          end
        end
        DIV_BUSY: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DIV_DONE;
            result_d = {rem_fix, quo_fix};
          end
        end
        DIV_BYZERO: begin
          state_d  = DIV_DONE;
          result_d = {quo_q, WIDTH'(DIV_BYZERO_QUO)};
        end
        DIV_DONE: begin
          if (!pipe_stall_i) state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  // Reset gates the stall so every output reads zero while rst is held.
  assign stall_div_o = start_i & (state_q != DIV_DONE) & ~annul_i & ~rst;
  assign ready_o     = (state_q == DIV_DONE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed DIV/DIVU results, stall lengths, annul,
// pipeline-stall hold, back-to-back issue and mid-divide reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, annul_i, pipe_stall_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stall_div_o;

  int errors = 0;
  int checks = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_i     (signed_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .pipe_stall_i (pipe_stall_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stall_div_o  (stall_div_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a divide, count stall cycles until ready, then check result while still in DONE.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_stall);
    int stalls = 0;
    bit seen = 0;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (ready_o) begin
        seen = 1;
        break;
      end
      if (stall_div_o) stalls++;
      @(posedge clk); #1;
      opdata1_i = 32'hDEAD_BEEF;  // forwarding noise after the latch cycle
      opdata2_i = 32'h0000_0003;
    end
    chk({tag, "_ready"}, 64'(seen), 64'd1);
    chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stall));
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_done_stall"}, 64'(stall_div_o), 64'd0);
  endtask

  task automatic leave_e(input string tag);
    @(posedge clk); #1;
    start_i = 1'b0;
    #2;
    chk({tag, "_idle_ready"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    int rdy_seen;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0; pipe_stall_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #12;
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_stall", 64'(stall_div_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    leave_e("divu_100_7");
    run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
    leave_e("div_m100_7");
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 33);
    leave_e("div_100_m7");
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    leave_e("div_ovf");
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 2);
    leave_e("divu_5_0");

    // Pipeline stall holds DONE for four cycles.
    run_div("hold", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    pipe_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, {32'd2, 32'd14});
    end
    pipe_stall_i = 1'b0;
    leave_e("hold");

    // Back-to-back: second issue starts in the IDLE cycle after DONE.
    run_div("b2b_9_2", 1'b0, 32'd9, 32'd2, {32'd1, 32'd4}, 33);
    run_div("b2b_8_4", 1'b0, 32'd8, 32'd4, {32'd0, 32'd2}, 33);
    leave_e("b2b_8_4");

    // Annul at cycle 10 of a divide.
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    #1;
    chk("annul_stall", 64'(stall_div_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (ready_o) rdy_seen++;
      @(posedge clk); #1;
    end
    chk("annul_no_ready", 64'(rdy_seen), 64'd0);

    // Reset at cycle 15 of a divide, then a clean divide.
    start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_result", result_o, 64'd0);
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_stall", 64'(stall_div_o), 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_div("post_rst", 1'b0, 32'd9, 32'd2, {32'd1, 32'd4}, 33);
    leave_e("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
